// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one unified memory port between the fetch side (F) and the data
//   side (M). The data side wins contention because it belongs to the older
//   instruction. A streak counter forces a fetch grant after DSTREAK_MAX
//   consecutive data grants made while a fetch was waiting.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   instr_req/instr_addr            fetch request (held until instrackF)
//   instrackF/instr_rdata           fetch acknowledge (low = stall) and data
//   data_req/we/be/addr/wdata       load/store request (held until dataackM)
//   dataackM/data_rdata             data acknowledge (low = stall) and data
//   mem_req/we/be/addr/wdata        memory access, held until mem_ready
//   mem_rdata/mem_ready             memory response (1-cycle ready pulse)
//   bus_error                       sticky watchdog flag
//
// Configuration
//   MEMARB_TIMEOUT_EN  enables a per-access watchdog: after TIMEOUT access
//                      cycles without mem_ready the access completes with
//                      zero read data and bus_error is set until reset.
//                      Without it bus_error is constant 0.
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int DSTREAK_MAX = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_req,
    input  logic [AW-1:0]   instr_addr,
    output logic            instrackF,
    output logic [DW-1:0]   instr_rdata,
    input  logic            data_req,
    input  logic            data_we,
    input  logic [DW/8-1:0] data_be,
    input  logic [AW-1:0]   data_addr,
    input  logic [DW-1:0]   data_wdata,
    output logic            dataackM,
    output logic [DW-1:0]   data_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ready,
    output logic            bus_error
);

    typedef enum logic [1:0] {IDLE, IACC, DACC, DONE} state_t;

    localparam int SW = $clog2(DSTREAK_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(DSTREAK_MAX);

    state_t        state, state_nxt;
    logic          grant_d;     // 1: current access belongs to the data side
    logic [SW-1:0] streak;
    logic          pick_d, pick_f, in_acc, finish, tmo_hit;

    assign in_acc    = (state == IACC) || (state == DACC);
    assign pick_d    = data_req && (!instr_req || (streak < SMAX));
    assign pick_f    = !pick_d && instr_req;
    assign finish    = in_acc && (mem_ready || tmo_hit);
    assign mem_req   = in_acc;
    assign instrackF = !instr_req || ((state == DONE) && !grant_d);
    assign dataackM  = !data_req  || ((state == DONE) && grant_d);

`ifdef MEMARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt;     // access cycles already spent before this one
    logic          bus_err_r;

    assign tmo_hit   = in_acc && !mem_ready && (tmo_cnt == CW'(TIMEOUT - 1));
    assign bus_error = bus_err_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt   <= '0;
            bus_err_r <= 1'b0;
        end else begin
            // Counter is zero whenever outside an access, so it starts clean.
            tmo_cnt <= in_acc ? tmo_cnt + 1'b1 : '0;
            if (tmo_hit)
                bus_err_r <= 1'b1;
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign bus_error = (TIMEOUT < 0);  // constant 0: no watchdog in this build
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_d)
                    state_nxt = DACC;
                else if (pick_f)
                    state_nxt = IACC;
            end
            IACC, DACC: begin
                if (finish)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_d     <= 1'b0;
            streak      <= '0;
            mem_we      <= 1'b0;
            mem_be      <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            instr_rdata <= '0;
            data_rdata  <= '0;
        end else begin
            if (state == IDLE) begin
                if (pick_d) begin
                    grant_d   <= 1'b1;
                    mem_we    <= data_we;
                    mem_be    <= data_we ? data_be : '1;
                    mem_addr  <= data_addr;
                    mem_wdata <= data_wdata;
                    // Only grants that make a fetch wait extend the streak.
                    if (!instr_req)
                        streak <= '0;
                    else if (streak != SMAX)
                        streak <= streak + 1'b1;
                end else if (pick_f) begin
                    grant_d   <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_be    <= '1;
                    mem_addr  <= instr_addr;
                    mem_wdata <= '0;
                    streak    <= '0;
                end
            end
            // A side that dropped its request (flush) does not take the data.
            if (finish) begin
                if (grant_d && data_req)
                    data_rdata <= mem_ready ? mem_rdata : '0;
                else if (!grant_d && instr_req)
                    instr_rdata <= mem_ready ? mem_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DMAX = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          instr_req = 1'b0;
    logic [AW-1:0] instr_addr = '0;
    logic          instrackF;
    logic [DW-1:0] instr_rdata;
    logic          data_req = 1'b0;
    logic          data_we = 1'b0;
    logic [3:0]    data_be = '0;
    logic [AW-1:0] data_addr = '0;
    logic [DW-1:0] data_wdata = '0;
    logic          dataackM;
    logic [DW-1:0] data_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic          bus_error;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .DSTREAK_MAX(DMAX), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instrackF(instrackF), .instr_rdata(instr_rdata),
        .data_req(data_req), .data_we(data_we), .data_be(data_be),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .dataackM(dataackM), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- memory responder ----------------
    int          fixed_lat = -1;   // -1: random latency 0..3
    bit          rd_fixed_en = 1'b0;
    logic [31:0] rd_fixed = '0;
    bit          spur_en = 1'b0;   // random ready pulses while no access
    int          lat = 0;

    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            if (lat == 0) begin
                mem_ready = 1'b1;
                mem_rdata = rd_fixed_en ? rd_fixed : $urandom;
            end else begin
                mem_ready = 1'b0;
                lat = lat - 1;
            end
        end else begin
            mem_ready = spur_en && ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
            lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3);
        end
    end

    // ---------------- behavioural reference model ----------------
    // The port is either free, carrying one access for a side, or in the
    // single acknowledge slot after that access. Fairness is derived from the
    // history of grants: the run of latest data grants that kept a fetch
    // waiting decides whether the fetch must now win.
    typedef struct packed { bit is_d; bit f_waiting; } grant_t;
    grant_t      glog[$];
    bit          busy = 0, ack_slot = 0, side_d = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_ir = '0, m_dr = '0;
    bit          m_we = 0;
    logic [3:0]  m_be = '0;

    function automatic int d_run();
        int n = 0;
        for (int i = glog.size() - 1; i >= 0; i--) begin
            if (!(glog[i].is_d && glog[i].f_waiting)) break;
            n++;
        end
        return (n > DMAX) ? DMAX : n;
    endfunction

    always @(negedge clk) begin
        chk("mem_req", mem_req, busy && !ack_slot);
        if (busy && !ack_slot) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", mem_we, m_we);
            chk("mem_be", mem_be, m_be);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("instrackF", instrackF, !instr_req || (ack_slot && !side_d));
        chk("dataackM", dataackM, !data_req || (ack_slot && side_d));
        chk("instr_rdata", instr_rdata, m_ir);
        chk("data_rdata", data_rdata, m_dr);
        chk("bus_error", bus_error, 1'b0);

        if (reset) begin
            busy = 0; ack_slot = 0; glog.delete(); m_ir = '0; m_dr = '0;
        end else if (!busy) begin
            if (data_req && (!instr_req || d_run() < DMAX)) begin
                busy = 1; side_d = 1;
                m_addr = data_addr; m_we = data_we; m_wdata = data_wdata;
                m_be = data_we ? data_be : 4'hF;
                glog.push_back('{is_d: 1'b1, f_waiting: instr_req});
            end else if (instr_req) begin
                busy = 1; side_d = 0;
                m_addr = instr_addr; m_we = 0; m_be = 4'hF;
                glog.push_back('{is_d: 1'b0, f_waiting: 1'b0});
            end
            if (glog.size() > 16) void'(glog.pop_front());
        end else if (!ack_slot) begin
            if (mem_ready) begin
                ack_slot = 1;
                if (side_d && data_req) m_dr = mem_rdata;
                if (!side_d && instr_req) m_ir = mem_rdata;
            end
        end else begin
            busy = 0; ack_slot = 0;
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic do_reset();
        instr_req = 0; data_req = 0; reset = 1;
        tick(); tick();
        reset = 0;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        instr_req = 0; data_req = 0;
        for (int i = 0; i < 100 && quiet < 3; i++) begin
            tick();
            if (!mem_req) quiet++; else quiet = 0;
        end
        chk("idle_reached", quiet >= 3, 1'b1);
    endtask

    initial begin
        bit saw_f, got, drop, iack, dack;
        int acks;
        logic [5:0] order;
        int ng;
        bit prev;

        // reset values
        do_reset();
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_instrackF", instrackF, 1);
        chk("rst_dataackM", dataackM, 1);
        chk("rst_rdata", {instr_rdata, data_rdata}, 0);

        // 1: single fetch, ready one cycle after mem_req
        fixed_lat = 1; rd_fixed_en = 1; rd_fixed = 32'h2402_0005;
        do_reset();
        instr_req = 1; instr_addr = 32'h100;
        tick(); #1 chk("t1_ack_c1", instrackF, 0);
        chk("t1_addr", mem_addr, 32'h100);
        tick(); #1 chk("t1_ack_c2", instrackF, 0);
        tick(); #1 chk("t1_ack_c3", instrackF, 1);
        chk("t1_rdata", instr_rdata, 32'h2402_0005);
        tick(); #1 chk("t1_ack_c4", instrackF, 0);
        wait_idle();

        // 2: simultaneous fetch and load, data first
        fixed_lat = 0; rd_fixed_en = 0;
        do_reset();
        instr_req = 1; instr_addr = 32'h100;
        data_req = 1; data_we = 0; data_addr = 32'h2000;
        tick(); #1 chk("t2_first_addr", mem_addr, 32'h2000);
        saw_f = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick(); #1;
            if (instrackF) saw_f = 1;
            if (dataackM) got = 1;
        end
        chk("t2_data_ack", got, 1);
        chk("t2_no_fetch_first", saw_f, 0);
        tick(); data_req = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick(); #1;
            if (mem_req) begin got = 1; chk("t2_second_addr", mem_addr, 32'h100); end
        end
        chk("t2_fetch_started", got, 1);
        wait_idle();

        // 3: back-to-back loads with a fetch waiting
        fixed_lat = -1;
        do_reset();
        instr_req = 1; instr_addr = 32'h100;
        data_req = 1; data_we = 0; data_addr = 32'h2000;
        order = '0; ng = 0; prev = 0;
        for (int i = 0; i < 200 && ng < 6; i++) begin
            tick(); #1;
            if (mem_req && !prev) begin
                order[ng] = (mem_addr == 32'h2000);
                ng++;
            end
            prev = mem_req;
        end
        chk("t3_grant_order", order, 6'b101111);
        wait_idle();

        // 4: store held until ready
        fixed_lat = 2;
        do_reset();
        data_req = 1; data_we = 1; data_be = 4'b0011;
        data_addr = 32'h3000; data_wdata = 32'hDEAD_BEEF;
        acks = 0; drop = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (drop) data_req = 0;
            #1;
            if (mem_req) begin
                chk("t4_we", mem_we, 1);
                chk("t4_be", mem_be, 4'b0011);
                chk("t4_wdata", mem_wdata, 32'hDEAD_BEEF);
            end
            if (dataackM && data_req) begin acks++; drop = 1; end
        end
        chk("t4_ack_pulses", acks, 1);
        data_we = 0;
        wait_idle();

        // 5: flushed fetch, then reset during a data access
        fixed_lat = 4; rd_fixed_en = 1; rd_fixed = 32'h55;
        do_reset();
        instr_req = 1; instr_addr = 32'h140;
        tick(); tick(); tick();
        instr_req = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick(); #1;
            chk("t5_flush_ack", instrackF, 1);
            if (!mem_req) got = 1;
        end
        chk("t5_access_done", got, 1);
        chk("t5_rdata_kept", instr_rdata, 0);
        fixed_lat = 1000;
        data_req = 1; data_we = 0; data_addr = 32'h2000;
        tick(); tick(); #1 chk("t5_dacc", mem_req, 1);
        reset = 1; data_req = 0;
        tick(); #1 chk("t5_rst_mem_req", mem_req, 0);
        reset = 0;
        tick(); #1 chk("t5_stay_idle", mem_req, 0);

        // random traffic
        fixed_lat = -1; rd_fixed_en = 0; spur_en = 1;
        do_reset();
        iack = 0; dack = 0;
        for (int n = 0; n < 4000; n++) begin
            tick();
            reset = ($urandom_range(0, 599) == 0);
            if (reset || (instr_req && iack)) instr_req = 0;
            else if (instr_req && $urandom_range(0, 63) == 0) instr_req = 0;
            else if (!instr_req && $urandom_range(0, 2) == 0) begin
                instr_req = 1; instr_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (reset || (data_req && dack)) data_req = 0;
            else if (data_req && $urandom_range(0, 63) == 0) data_req = 0;
            else if (!data_req && $urandom_range(0, 1) == 0) begin
                data_req = 1; data_we = $urandom_range(0, 1);
                data_be = $urandom; data_addr = $urandom; data_wdata = $urandom;
            end
            #1;
            iack = instrackF && instr_req;
            dack = dataackM && data_req;
        end
        reset = 0;
        wait_idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
